// File: rtl/bp_me_trace_replay_checker.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_trace_replay_checker
// Brief    : Multi-channel trace replay gate and completion checker. Passes
//            trace packets to the memory system under test while limiting the
//            requests each channel may have in flight, counts issued requests
//            and returned responses, runs a global progress watchdog and
//            latches one done/error outcome with the first failing channel.
// Options  : BP_TRACE_CHECK_DATA_EN - when defined, each response is compared
//            against the expected-response stream (error code 3 on mismatch).
//            When undefined, exp_yumi_o is held 0 and exp_* inputs are ignored.
// Ports    : clk_i, reset_n_i (async, active-low)
//            tr_v_i/tr_data_i/tr_yumi_o       trace ROM side, per channel
//            pkt_v_o/pkt_data_o/pkt_ready_i   request side toward the DUT
//            resp_v_i/resp_data_i             DUT responses (pulse, no backpressure)
//            exp_v_i/exp_data_i/exp_yumi_o    expected-response stream
//            issue_count_o/resp_count_o       per-channel counters
//            done_o/error_o/error_code_o/error_chan_o  outcome
// Revision : 1.0 - initial release
// ============================================================================
module bp_me_trace_replay_checker #(
    parameter int num_channels_p    = 2,
    parameter int ring_width_p      = 100,
    parameter int data_width_p      = 64,
    parameter int instr_count_p     = 1024,
    parameter int max_outstanding_p = 4,
    parameter int timeout_cycles_p  = 1000000
) (
    input  logic                                              clk_i,
    input  logic                                              reset_n_i,
    input  logic [num_channels_p-1:0]                         tr_v_i,
    input  logic [num_channels_p*ring_width_p-1:0]            tr_data_i,
    output logic [num_channels_p-1:0]                         tr_yumi_o,
    output logic [num_channels_p-1:0]                         pkt_v_o,
    output logic [num_channels_p*ring_width_p-1:0]            pkt_data_o,
    input  logic [num_channels_p-1:0]                         pkt_ready_i,
    input  logic [num_channels_p-1:0]                         resp_v_i,
    input  logic [num_channels_p*data_width_p-1:0]            resp_data_i,
    input  logic [num_channels_p-1:0]                         exp_v_i,
    input  logic [num_channels_p*data_width_p-1:0]            exp_data_i,
    output logic [num_channels_p-1:0]                         exp_yumi_o,
    output logic [num_channels_p*$clog2(instr_count_p+1)-1:0] issue_count_o,
    output logic [num_channels_p*$clog2(instr_count_p+1)-1:0] resp_count_o,
    output logic                                              done_o,
    output logic                                              error_o,
    output logic [1:0]                                        error_code_o,
    output logic [((num_channels_p > 1) ? $clog2(num_channels_p) : 1)-1:0] error_chan_o
);

    localparam int c_cw  = $clog2(instr_count_p + 1);
    localparam int c_ow  = $clog2(max_outstanding_p + 1);
    localparam int c_ww  = $clog2(timeout_cycles_p + 1);
    localparam int c_chw = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;

    localparam logic [c_cw-1:0] c_instr      = c_cw'(instr_count_p);
    localparam logic [c_cw-1:0] c_cnt_one    = c_cw'(1);
    localparam logic [c_ow-1:0] c_max_out    = c_ow'(max_outstanding_p);
    localparam logic [c_ow-1:0] c_out_one    = c_ow'(1);
    localparam logic [c_ww-1:0] c_wd_one     = c_ww'(1);
    localparam logic [c_ww-1:0] c_timeout_m1 = c_ww'(timeout_cycles_p - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DONE  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t                    r_state;
    logic [c_ww-1:0]           r_wd;
    logic [1:0]                r_err_code;
    logic [c_chw-1:0]          r_err_chan;

    // Gated by reset_n_i so handshakes drop the moment reset asserts,
    // before the state register has been observed in its reset value.
    logic                      w_run;
    logic [num_channels_p-1:0] w_yumi;
    logic [num_channels_p-1:0] w_resp;
    logic [num_channels_p-1:0] w_spur;
    logic [num_channels_p-1:0] w_mism;
    logic [num_channels_p-1:0] w_resp_full;
    logic                      w_progress;
    logic                      w_wd_expire;
    logic                      w_err_hit;
    logic [1:0]                w_err_code;
    logic [c_chw-1:0]          w_err_chan;

    assign w_run      = (r_state == ST_RUN) & reset_n_i;
    assign pkt_data_o = tr_data_i;
    assign tr_yumi_o  = w_yumi;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_chan
        logic [c_cw-1:0] r_issue_cnt;
        logic [c_cw-1:0] r_resp_cnt;
        logic [c_ow-1:0] r_outst;
        logic            w_resp_ok;

        assign pkt_v_o[c] = tr_v_i[c] & w_run & (r_issue_cnt < c_instr) & (r_outst < c_max_out);
        assign w_yumi[c]  = pkt_v_o[c] & pkt_ready_i[c];
        assign w_resp[c]  = resp_v_i[c] & w_run;
        // Uses the registered outstanding count, so a response landing in the
        // same cycle as its own issue handshake is treated as spurious.
        assign w_spur[c]  = w_resp[c] & ((r_outst == '0) | (r_resp_cnt == c_instr));
        assign w_resp_ok  = w_resp[c] & ~w_spur[c];

`ifdef BP_TRACE_CHECK_DATA_EN
        assign exp_yumi_o[c] = w_resp[c] & exp_v_i[c];
        assign w_mism[c]     = w_resp[c] &
                               (~exp_v_i[c] |
                                (exp_data_i[c*data_width_p +: data_width_p] !=
                                 resp_data_i[c*data_width_p +: data_width_p]));
`else
        assign exp_yumi_o[c] = 1'b0;
        assign w_mism[c]     = 1'b0;
`endif

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_issue_cnt <= '0;
                r_resp_cnt  <= '0;
                r_outst     <= '0;
            end else begin
                // Both increments are already bounded: issue is gated below
                // the limit and spurious responses never reach w_resp_ok.
                if (w_yumi[c]) begin
                    r_issue_cnt <= r_issue_cnt + c_cnt_one;
                end
                if (w_resp_ok) begin
                    r_resp_cnt <= r_resp_cnt + c_cnt_one;
                end
                if (w_yumi[c] & ~w_resp_ok) begin
                    r_outst <= r_outst + c_out_one;
                end else if (~w_yumi[c] & w_resp_ok) begin
                    r_outst <= r_outst - c_out_one;
                end
            end
        end

        assign w_resp_full[c]                 = (r_resp_cnt == c_instr);
        assign issue_count_o[c*c_cw +: c_cw]  = r_issue_cnt;
        assign resp_count_o[c*c_cw +: c_cw]   = r_resp_cnt;
    end

`ifndef BP_TRACE_CHECK_DATA_EN
    logic w_unused_data;
    assign w_unused_data = ^{resp_data_i, exp_data_i, exp_v_i};
`endif

    assign w_progress  = (|w_yumi) | (|w_resp);
    assign w_wd_expire = w_run & ~w_progress & (r_wd == c_timeout_m1);

    // Scan from the top channel down so the lowest-numbered offender is the
    // last writer; a data mismatch outranks a spurious response on a channel.
    always_comb begin
        w_err_hit  = 1'b0;
        w_err_code = 2'd0;
        w_err_chan = '0;
        for (int c = num_channels_p - 1; c >= 0; c--) begin
            if (w_mism[c] | w_spur[c]) begin
                w_err_hit  = 1'b1;
                w_err_code = w_mism[c] ? 2'd3 : 2'd2;
                w_err_chan = c_chw'(c);
            end
        end
        if (!w_err_hit && w_wd_expire) begin
            w_err_hit  = 1'b1;
            w_err_code = 2'd1;
            w_err_chan = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= ST_RUN;
            r_wd       <= '0;
            r_err_code <= 2'd0;
            r_err_chan <= '0;
        end else if (r_state == ST_RUN) begin
            r_wd <= w_progress ? '0 : (r_wd + c_wd_one);
            if (w_err_hit) begin
                r_state    <= ST_ERROR;
                r_err_code <= w_err_code;
                r_err_chan <= w_err_chan;
            end else if (&w_resp_full) begin
                r_state <= ST_DONE;
            end
        end
    end

    assign done_o       = (r_state == ST_DONE);
    assign error_o      = (r_state == ST_ERROR);
    assign error_code_o = r_err_code;
    assign error_chan_o = r_err_chan;

endmodule
`default_nettype wire

// File: tb/tb_bp_me_trace_replay_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_me_trace_replay_checker
// Brief    : Self-checking bench for bp_me_trace_replay_checker: hand-built
//            vector table, directed error/timeout/reset sequences, and random
//            traffic checked against a counter-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_me_trace_replay_checker;

    localparam int N  = 2;
    localparam int RW = 16;
    localparam int DW = 16;
    localparam int IC = 8;
    localparam int MO = 2;
    localparam int TO = 50;
    localparam int CW = 4;

`ifdef BP_TRACE_CHECK_DATA_EN
    localparam bit DATA_EN = 1'b1;
`else
    localparam bit DATA_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    tr_v, tr_yumi, pkt_v, pkt_ready, resp_v, exp_v, exp_yumi;
    logic [N*RW-1:0] tr_data, pkt_data;
    logic [N*DW-1:0] resp_data, exp_data;
    logic [N*CW-1:0] issue_count, resp_count;
    logic            done, error;
    logic [1:0]      error_code;
    logic [0:0]      error_chan;

    always #5 clk = ~clk;

    bp_me_trace_replay_checker #(
        .num_channels_p   (N),
        .ring_width_p     (RW),
        .data_width_p     (DW),
        .instr_count_p    (IC),
        .max_outstanding_p(MO),
        .timeout_cycles_p (TO)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .tr_v_i       (tr_v),
        .tr_data_i    (tr_data),
        .tr_yumi_o    (tr_yumi),
        .pkt_v_o      (pkt_v),
        .pkt_data_o   (pkt_data),
        .pkt_ready_i  (pkt_ready),
        .resp_v_i     (resp_v),
        .resp_data_i  (resp_data),
        .exp_v_i      (exp_v),
        .exp_data_i   (exp_data),
        .exp_yumi_o   (exp_yumi),
        .issue_count_o(issue_count),
        .resp_count_o (resp_count),
        .done_o       (done),
        .error_o      (error),
        .error_code_o (error_code),
        .error_chan_o (error_chan)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: counts and outcome per the rules, one call per cycle.
    int       m_iss[N];
    int       m_rsp[N];
    int       m_out[N];
    int       m_idle;
    bit       m_done, m_err;
    int       m_code, m_chan;
    logic [N-1:0] m_yumi;
    int       cyc;
    int       due_q[N][$];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_iss[c] = 0; m_rsp[c] = 0; m_out[c] = 0;
            due_q[c].delete();
        end
        m_idle = 0; m_done = 0; m_err = 0; m_code = 0; m_chan = 0;
        m_yumi = '0; cyc = 0;
    endtask

    task automatic model_cycle();
        logic [N-1:0]    pv, y, ey, spur;
        logic [N*CW-1:0] e_ic, e_rc;
        bit run, prog, hit, alldone, mis;
        int code, chan;
        run = !m_done && !m_err;
        prog = 0; hit = 0; alldone = 1; code = 0; chan = 0;
        for (int c = 0; c < N; c++) begin
            pv[c] = tr_v[c] && run && (m_iss[c] < IC) && (m_out[c] < MO);
            y[c]  = pv[c] && pkt_ready[c];
            ey[c] = DATA_EN && run && resp_v[c] && exp_v[c];
            spur[c] = run && resp_v[c] && (m_out[c] == 0 || m_rsp[c] == IC);
            e_ic[c*CW +: CW] = CW'(m_iss[c]);
            e_rc[c*CW +: CW] = CW'(m_rsp[c]);
        end
        check("handshake", {pkt_v, tr_yumi, exp_yumi}, {pv, y, ey});
        check("pkt_data", pkt_data, tr_data);
        check("counts", {issue_count, resp_count}, {e_ic, e_rc});
        check("status", {done, error, error_code, error_chan},
              {m_done, m_err, m_code[1:0], m_chan[0]});
        if (run) begin
            for (int c = 0; c < N; c++) begin
                mis = DATA_EN && resp_v[c] &&
                      (!exp_v[c] || exp_data[c*DW +: DW] != resp_data[c*DW +: DW]);
                if (!hit && (spur[c] || mis)) begin
                    hit = 1; code = mis ? 3 : 2; chan = c;
                end
                if (y[c] || resp_v[c]) prog = 1;
                if (m_rsp[c] != IC) alldone = 0;
            end
            for (int c = 0; c < N; c++) begin
                if (y[c]) begin m_iss[c]++; m_out[c]++; end
                if (resp_v[c] && !spur[c]) begin m_rsp[c]++; m_out[c]--; end
            end
            m_idle = prog ? 0 : m_idle + 1;
            if (hit) begin
                m_err = 1; m_code = code; m_chan = chan;
            end else if (!prog && m_idle == TO) begin
                m_err = 1; m_code = 1; m_chan = 0;
            end else if (alldone) begin
                m_done = 1;
            end
        end
        m_yumi = y;
    endtask

    task automatic idle_inputs();
        tr_v = '0; pkt_ready = '0; resp_v = '0; exp_v = '0;
        tr_data = '0; resp_data = '0; exp_data = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // DUT emulator + model check; starts and ends on a falling edge.
    task automatic run_traffic(input int max_cycles, input bit rnd, input bit hold,
                               input int lat_min, input int lat_max);
        for (int i = 0; i < max_cycles; i++) begin
            for (int c = 0; c < N; c++) begin
                tr_v[c]      = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                pkt_ready[c] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                resp_v[c]    = !hold && due_q[c].size() > 0 && due_q[c][0] <= cyc;
                tr_data[c*RW +: RW]   = RW'($urandom);
                resp_data[c*DW +: DW] = DW'($urandom);
            end
            exp_v = resp_v;
            exp_data = resp_data;
            #1;
            model_cycle();
            for (int c = 0; c < N; c++) begin
                if (resp_v[c]) void'(due_q[c].pop_front());
                if (m_yumi[c]) due_q[c].push_back(cyc + $urandom_range(lat_min, lat_max));
            end
            cyc++;
            @(negedge clk);
            if (m_done || m_err) break;
        end
    endtask

    typedef struct {
        logic [1:0] tv, rdy, rsp, pv, y;
        logic [3:0] i0, i1, r0, r1;
    } vec_t;

    vec_t tbl[8];
    int   since;
    bit   seen;

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0, 4'd0};
        tbl[1] = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 4'd0, 4'd0, 4'd0, 4'd0};
        tbl[2] = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 4'd1, 4'd0, 4'd0, 4'd0};
        tbl[3] = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 4'd2, 4'd1, 4'd0, 4'd0};
        tbl[4] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 4'd2, 4'd2, 4'd0, 4'd0};
        tbl[5] = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 4'd2, 4'd2, 4'd1, 4'd0};
        tbl[6] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 4'd3, 4'd2, 4'd2, 4'd0};
        tbl[7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd3, 4'd2, 4'd3, 4'd1};

        // Reset state
        do_reset();
        #1;
        check("rst_counts", {issue_count, resp_count}, 0);
        check("rst_status", {done, error, error_code, error_chan}, 0);
        check("rst_hs", {pkt_v, tr_yumi, exp_yumi}, 0);
        @(negedge clk);

        // Vector table: issue gating, outstanding cap, simultaneous issue/response
        for (int i = 0; i < 8; i++) begin
            tr_v = tbl[i].tv; pkt_ready = tbl[i].rdy; resp_v = tbl[i].rsp;
            exp_v = tbl[i].rsp;
            #1;
            check($sformatf("tbl%0d_hs", i), {pkt_v, tr_yumi}, {tbl[i].pv, tbl[i].y});
            check($sformatf("tbl%0d_cnt", i), {issue_count, resp_count},
                  {tbl[i].i1, tbl[i].i0, tbl[i].r1, tbl[i].r0});
            @(negedge clk);
        end

        // Full replay, responses 3 cycles after issue
        do_reset();
        run_traffic(400, 1'b0, 1'b0, 3, 3);
        #1;
        check("main_done", {done, error}, 2'b10);
        check("main_resp_count", resp_count, {4'd8, 4'd8});
        @(negedge clk);

        // Withheld responses: issue stops at the outstanding cap
        do_reset();
        run_traffic(10, 1'b0, 1'b1, 1, 1);
        #1;
        check("hold_issue_count", issue_count, {4'd2, 4'd2});
        check("hold_pkt_v", {pkt_v, tr_v}, {2'b00, 2'b11});
        @(negedge clk);
        run_traffic(600, 1'b1, 1'b0, 1, 5);
        #1;
        check("hold_release_done", {done, error}, 2'b10);
        @(negedge clk);

        // Spurious response on channel 1 with nothing outstanding
        do_reset();
        resp_v = 2'b10; exp_v = 2'b10;
        @(negedge clk);
        resp_v = '0; exp_v = '0;
        #1;
        check("spur1_status", {done, error, error_code, error_chan}, {1'b0, 1'b1, 2'd2, 1'b1});
        tr_v = 2'b11; pkt_ready = 2'b11; resp_v = 2'b01; exp_v = 2'b01;
        #1;
        check("spur1_frozen_hs", {pkt_v, tr_yumi, exp_yumi}, 0);
        @(negedge clk);
        #1;
        check("spur1_frozen", {error_code, error_chan, issue_count, resp_count}, {2'd2, 1'b1, 16'h0});

        // Two simultaneous spurious responses: channel 0 reported
        do_reset();
        resp_v = 2'b11; exp_v = 2'b11;
        @(negedge clk);
        resp_v = '0; exp_v = '0;
        #1;
        check("spur01_status", {error, error_code, error_chan}, {1'b1, 2'd2, 1'b0});

        // Data mismatch on channel 0 alongside spurious channel 1
        do_reset();
        tr_v = 2'b01; pkt_ready = 2'b01;
        @(negedge clk);
        tr_v = '0; resp_v = 2'b11; exp_v = 2'b11;
        resp_data = {16'h1111, 16'hDEAD};
        exp_data  = {16'h1111, 16'hBEEF};
        #1;
        check("mism_exp_yumi", exp_yumi, DATA_EN ? 2'b11 : 2'b00);
        @(negedge clk);
        resp_v = '0; exp_v = '0;
        #1;
        check("mism_status", {error, error_code, error_chan},
              DATA_EN ? {1'b1, 2'd3, 1'b0} : {1'b1, 2'd2, 1'b1});

        // Watchdog: error exactly TO edges after the last progress
        do_reset();
        tr_v = 2'b11; pkt_ready = 2'b11;
        since = 0; seen = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (error) begin seen = 1; break; end
            if (|tr_yumi) since = 0; else since++;
            @(negedge clk);
        end
        check("timeout_seen", seen, 1'b1);
        check("timeout_latency", since, TO);
        check("timeout_code", {error_code, error_chan}, {2'd1, 1'b0});

        // Asynchronous reset mid-run, then a clean replay
        do_reset();
        run_traffic(15, 1'b1, 1'b0, 1, 5);
        tr_v = 2'b11; pkt_ready = 2'b11; resp_v = '0; exp_v = '0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_hs", {pkt_v, tr_yumi}, 0);
        check("async_rst_counts", {issue_count, resp_count}, 0);
        do_reset();
        run_traffic(600, 1'b1, 1'b0, 1, 5);
        #1;
        check("after_rst_done", {done, error, resp_count}, {2'b10, 4'd8, 4'd8});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
